// File: rtl/gn_arb_pkg.sv
// gn_arb_pkg: shared constants and types for the golden-nonce arbiter.
//   ENTRY_W    : width of one buffered entry ({core index, nonce})
//   DROP_CNT_W : width of the saturating drop counter
//   NCORES_MAX : most hashcores one arbiter can serve
package gn_arb_pkg;

  localparam int CORE_W     = 2;
  localparam int NONCE_W    = 32;
  localparam int ENTRY_W    = CORE_W + NONCE_W;
  localparam int DROP_CNT_W = 8;
  localparam int NCORES_MAX = 4;

  typedef struct packed {
    logic [CORE_W-1:0]  core;
    logic [NONCE_W-1:0] nonce;
  } entry_t;

endpackage

// File: rtl/gn_fifo.sv
// gn_fifo: first-word-fall-through FIFO with synchronous flush.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : empties the FIFO; wins over push and pop
//   push, push_data   : write request, accepted only when not full
//   pop, pop_data     : read request and head entry (valid while !empty)
//   full, empty, level: status, evaluated from registered state
// Storage is never reset; only the pointers and occupancy are.
module gn_fifo #(
  parameter int DATA_W = 34,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q,  level_d;
  logic              push_ok;
  logic              pop_ok;

  // Full is taken from the registered level, so a pop in the same cycle
  // does not make room for a push.
  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/golden_nonce_arbiter.sv
// golden_nonce_arbiter: gathers golden-nonce strobes from up to four
// hashcores into one buffered stream for the comms block.
//   hash_clk, reset_n : clock, asynchronous active-low reset (release is
//                       synchronised internally)
//   core_nonce        : nonce of core i at bits [32i+31:32i]
//   core_match        : one-cycle match strobe per core
//   new_work          : one-cycle pulse, flushes slots, FIFO and rr pointer
//   out_nonce/out_core: FIFO head (zero while out_valid is low)
//   out_valid/out_ready: head handshake
//   fifo_level        : FIFO occupancy
//   drop_cnt          : saturating count of strobes lost to a full slot
module golden_nonce_arbiter
  import gn_arb_pkg::*;
#(
  parameter int NCORES     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          hash_clk,
  input  logic                          reset_n,
  input  logic [32*NCORES-1:0]          core_nonce,
  input  logic [NCORES-1:0]             core_match,
  input  logic                          new_work,
  output logic [31:0]                   out_nonce,
  output logic [1:0]                    out_core,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  function automatic logic [DROP_CNT_W-1:0] sat_add_drop(
    input logic [DROP_CNT_W-1:0] cnt,
    input logic [2:0]            inc
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_CNT_W-2){1'b0}}, inc};
    if (sum[DROP_CNT_W]) return '1;
    else                 return sum[DROP_CNT_W-1:0];
  endfunction

  // Reset: assert asynchronously, release two edges after reset_n rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_i;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_i    = rst_sync_q[1];

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  // Inputs widened to NCORES_MAX so every index below is a clean 2-bit one;
  // the unused upper slots never see a strobe and stay invalid.
  logic [NONCE_W*NCORES_MAX-1:0] core_nonce_w;
  logic [NONCE_W-1:0]            nonce_pad [NCORES_MAX];
  logic [NCORES_MAX-1:0]         match_pad;

  assign core_nonce_w = (NONCE_W*NCORES_MAX)'(core_nonce);
  assign match_pad    = NCORES_MAX'(core_match);

  always_comb begin
    for (int i = 0; i < NCORES_MAX; i++) begin
      nonce_pad[i] = core_nonce_w[NONCE_W*i +: NONCE_W];
    end
  end

  logic [NCORES_MAX-1:0] slot_vld_q, slot_vld_d;
  logic [NONCE_W-1:0]    slot_nonce_q [NCORES_MAX];
  logic [NONCE_W-1:0]    slot_nonce_d [NCORES_MAX];
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  can_grant;
  logic                  grant_any;
  logic [1:0]            grant_idx;
  logic [NCORES_MAX-1:0] grant_pad;
  logic [2:0]            cand;
  logic [2:0]            rr_next;
  logic [2:0]            drop_inc;
  entry_t                push_entry;
  entry_t                head_entry;

  assign can_grant = !fifo_full && !new_work;

  // Stage: round-robin grant over the valid slots, searching from rr_ptr.
  always_comb begin
    grant_pad = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int off = 0; off < NCORES; off++) begin
      cand = {1'b0, rr_ptr_q} + 3'(off);
      if (cand >= 3'(NCORES)) cand = cand - 3'(NCORES);
      if (can_grant && !grant_any && slot_vld_q[cand[1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[1:0];
      end
    end
    grant_pad[grant_idx] = grant_any;
  end

  always_comb begin
    rr_next = {1'b0, grant_idx} + 3'd1;
    if (rr_next >= 3'(NCORES)) rr_next = '0;
    rr_ptr_d = rr_ptr_q;
    if (new_work)       rr_ptr_d = '0;
    else if (grant_any) rr_ptr_d = rr_next[1:0];
  end

  // Stage: holding slots. A slot being granted this cycle may be reloaded
  // by a fresh strobe; otherwise a strobe into a full slot is a drop.
  always_comb begin
    slot_vld_d   = slot_vld_q;
    slot_nonce_d = slot_nonce_q;
    drop_inc     = '0;
    if (new_work) begin
      slot_vld_d = '0;
    end else begin
      for (int i = 0; i < NCORES_MAX; i++) begin
        if (match_pad[i]) begin
          if (!slot_vld_q[i] || grant_pad[i]) begin
            slot_vld_d[i]   = 1'b1;
            slot_nonce_d[i] = nonce_pad[i];
          end else begin
            drop_inc = drop_inc + 3'd1;
          end
        end else if (grant_pad[i]) begin
          slot_vld_d[i] = 1'b0;
        end
      end
    end
    drop_cnt_d = sat_add_drop(drop_cnt_q, drop_inc);
  end

  always_ff @(posedge hash_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_vld_q <= '0;
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge hash_clk) begin
    slot_nonce_q <= slot_nonce_d;
  end

  // Stage: output FIFO; the granted slot is pushed on the same edge.
  assign push_entry.core  = grant_idx;
  assign push_entry.nonce = slot_nonce_q[grant_idx];

  gn_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (hash_clk),
    .rst_n     (rst_n_i),
    .flush     (new_work),
    .push      (grant_any),
    .push_data (push_entry),
    .pop       (out_valid && out_ready),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Head is masked while empty so the un-reset storage never shows.
  assign out_valid = !fifo_empty;
  assign out_nonce = out_valid ? head_entry.nonce : '0;
  assign out_core  = out_valid ? head_entry.core  : '0;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
module tb_golden_nonce_arbiter;

  localparam int NCORES     = 4;
  localparam int FIFO_DEPTH = 8;

  logic         hash_clk = 1'b0;
  logic         reset_n  = 1'b1;
  logic [127:0] core_nonce = '0;
  logic [3:0]   core_match = '0;
  logic         new_work   = 1'b0;
  logic         out_ready  = 1'b0;
  logic [31:0]  out_nonce;
  logic [1:0]   out_core;
  logic         out_valid;
  logic [3:0]   fifo_level;
  logic [7:0]   drop_cnt;

  golden_nonce_arbiter #(
    .NCORES     (NCORES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .hash_clk   (hash_clk),
    .reset_n    (reset_n),
    .core_nonce (core_nonce),
    .core_match (core_match),
    .new_work   (new_work),
    .out_nonce  (out_nonce),
    .out_core   (out_core),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 hash_clk = ~hash_clk;

  typedef struct packed {
    logic [1:0]  core;
    logic [31:0] nonce;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge hash_clk);
      #1;
    end
  endtask

  task automatic strobe(input int c, input logic [31:0] n);
    core_match[c]         = 1'b1;
    core_nonce[32*c +: 32] = n;
  endtask

  task automatic expect_entry(input int c, input logic [31:0] n);
    exp_t e;
    e.core  = 2'(c);
    e.nonce = n;
    sb_q.push_back(e);
  endtask

  task automatic clr_inputs();
    core_match = '0;
    new_work   = 1'b0;
  endtask

  // Scoreboard: the head is consumed at the next rising edge.
  always @(negedge hash_clk) begin
    if (mon_en && reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_entry: observed core %0d nonce %h, expected no entry",
               out_core, out_nonce);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_nonce", out_nonce, e.nonce);
        check("sb_core", 32'(out_core), 32'(e.core));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_nonce", out_nonce, 32'd0);
    check("rst_core", 32'(out_core), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    tick(3);
    #2 reset_n = 1'b1;
    tick(4);
    mon_en    = 1'b1;
    out_ready = 1'b1;

    // Single strobe, 2-cycle latency, one cycle wide
    strobe(2, 32'h3fbd9207);
    expect_entry(2, 32'h3fbd9207);
    tick();
    clr_inputs();
    check("t1_valid_k", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid_k1", 32'(out_valid), 32'd1);
    check("t1_nonce", out_nonce, 32'h3fbd9207);
    check("t1_core", 32'(out_core), 32'd2);
    tick();
    check("t1_one_wide", 32'(out_valid), 32'd0);
    check("t1_rr", 32'(dut.rr_ptr_q), 32'd3);

    // All four strobe with rr_ptr=3 -> order 3,0,1,2
    for (int c = 0; c < 4; c++) strobe(c, 32'ha0000000 + 32'(c));
    expect_entry(3, 32'ha0000003);
    expect_entry(0, 32'ha0000000);
    expect_entry(1, 32'ha0000001);
    expect_entry(2, 32'ha0000002);
    tick();
    clr_inputs();
    tick(6);
    check("rr3_drained", 32'(sb_q.size()), 32'd0);
    check("rr3_ptr", 32'(dut.rr_ptr_q), 32'd3);

    // Flush resets rr_ptr; all four strobe -> order 0,1,2,3
    new_work = 1'b1;
    tick();
    clr_inputs();
    check("flush_rr", 32'(dut.rr_ptr_q), 32'd0);
    for (int c = 0; c < 4; c++) strobe(c, 32'hb0000000 + 32'(c));
    for (int c = 0; c < 4; c++) expect_entry(c, 32'hb0000000 + 32'(c));
    tick();
    clr_inputs();
    tick(6);
    check("rr0_drained", 32'(sb_q.size()), 32'd0);
    check("rr0_ptr", 32'(dut.rr_ptr_q), 32'd0);
    check("rr0_drop", 32'(drop_cnt), 32'd0);

    // Back-pressure: 12 back-to-back strobes from core 0 into depth 8
    out_ready = 1'b0;
    for (int j = 0; j < 12; j++) begin
      strobe(0, 32'h100 + 32'(j));
      if (j < 9) expect_entry(0, 32'h100 + 32'(j));
      tick();
    end
    clr_inputs();
    tick();
    check("bp_level", 32'(fifo_level), 32'd8);
    check("bp_slot_vld", 32'(dut.slot_vld_q[0]), 32'd1);
    check("bp_slot_nonce", dut.slot_nonce_q[0], 32'h108);
    check("bp_drop", 32'(drop_cnt), 32'd3);
    check("bp_head_valid", 32'(out_valid), 32'd1);
    check("bp_head_nonce", out_nonce, 32'h100);
    tick(2);
    check("bp_head_stable", out_nonce, 32'h100);
    out_ready = 1'b1;
    tick(14);
    check("bp_drained", 32'(sb_q.size()), 32'd0);
    check("bp_level_end", 32'(fifo_level), 32'd0);

    // Flush with 5 entries held and a same-cycle strobe from core 1
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      strobe(0, 32'h200 + 32'(j));
      tick();
    end
    clr_inputs();
    tick();
    check("fl_level_pre", 32'(fifo_level), 32'd5);
    new_work = 1'b1;
    strobe(1, 32'hdead0001);
    tick();
    clr_inputs();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_level", 32'(fifo_level), 32'd0);
    check("fl_drop", 32'(drop_cnt), 32'd3);
    check("fl_slot1", 32'(dut.slot_vld_q[1]), 32'd0);
    out_ready = 1'b1;
    tick(6);
    check("fl_no_output", 32'(fifo_level), 32'd0);

    // Drop counter saturation
    out_ready = 1'b0;
    for (int j = 0; j < 310; j++) begin
      strobe(3, 32'h300 + 32'(j));
      tick();
      if (j == 19) check("sat_partial", 32'(drop_cnt), 32'd14);
    end
    clr_inputs();
    tick();
    check("sat_drop", 32'(drop_cnt), 32'd255);
    new_work = 1'b1;
    tick();
    clr_inputs();
    check("sat_after_flush", 32'(drop_cnt), 32'd255);
    check("sat_flush_level", 32'(fifo_level), 32'd0);

    // Asynchronous reset mid-burst
    for (int c = 0; c < 4; c++) strobe(c, 32'hc0000000 + 32'(c));
    tick();
    clr_inputs();
    tick(2);
    check("ar_level_pre", 32'(fifo_level), 32'd2);
    #3 reset_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_nonce", out_nonce, 32'd0);
    check("ar_core", 32'(out_core), 32'd0);
    check("ar_level", 32'(fifo_level), 32'd0);
    check("ar_drop", 32'(drop_cnt), 32'd0);
    tick(2);
    #2 reset_n = 1'b1;
    tick(4);
    check("ar_slots", 32'(dut.slot_vld_q), 32'd0);
    out_ready = 1'b1;
    strobe(1, 32'h5a5a1234);
    expect_entry(1, 32'h5a5a1234);
    tick();
    clr_inputs();
    check("ar_lat_k", 32'(out_valid), 32'd0);
    tick();
    check("ar_lat_valid", 32'(out_valid), 32'd1);
    check("ar_lat_nonce", out_nonce, 32'h5a5a1234);
    check("ar_lat_core", 32'(out_core), 32'd1);
    tick();
    check("ar_lat_done", 32'(out_valid), 32'd0);
    check("ar_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/golden_nonce_arbiter.md
# golden_nonce_arbiter

Collects golden-nonce match strobes from up to four parallel hashcore instances, each running its own nonce_msb prefix, and serialises them into one buffered stream for the serial/JTAG comms block. Per-core holding slots, a round-robin arbiter and a FIFO absorb bursts and simultaneous matches, so no strobe is lost while the consumer is busy. A new-work flush discards stale nonces. Saturating counters report drops.

## Interface
Parameters:
- NCORES, 4, number of hashcores served (1..4)
- FIFO_DEPTH, 8, output FIFO entries (power of 2, 2..32)

Ports:
- hash_clk  in  1  sole clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- core_nonce  in  32*NCORES  golden_nonce of core i at bits [32i+31:32i]
- core_match  in  NCORES  one-cycle match strobe of core i
- new_work  in  1  one-cycle pulse: flush slots and FIFO
- out_nonce  out  32  nonce at FIFO head
- out_core  out  2  index of the core that produced out_nonce
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head entry when out_valid is high
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- drop_cnt  out  8  saturating count of strobes lost to a full slot

## Operation
- Slot i: {valid, nonce}. On core_match[i] with slot empty or being granted this cycle → load core_nonce[i], set valid. On core_match[i] with slot full and not granted → drop the new nonce; drop_cnt +1, saturates at 255.
- Arbiter: among valid slots, grant exactly one per cycle, round-robin starting at rr_ptr. Grant only when the FIFO is not full. On a grant, push {core idx, nonce}, clear the slot unless it is reloaded the same cycle, and set rr_ptr = granted+1 mod NCORES.
- FIFO: first-word-fall-through. out_valid = !empty. Pop on out_valid && out_ready. Full is evaluated before a same-cycle pop, so a full FIFO refuses a push even while popping. Push and pop in the same cycle leave the level unchanged.
- Flush: new_work clears all slots, the FIFO (level 0) and rr_ptr. A core_match in the same cycle as new_work is discarded and not counted. Flush does not clear drop_cnt.
- Core tag check: core_nonce[i][31:30] is not compared against i; out_core carries the slot index.

## Timing
- Reset (async assert, release synchronised to hash_clk): all slots invalid, FIFO empty, rr_ptr=0, out_valid=0, out_nonce=0, out_core=0, fifo_level=0, drop_cnt=0.
- Latency: strobe sampled at edge k → slot valid after k → pushed at edge k+1 (if granted) → out_valid high after k+1. Minimum latency is 2 cycles.
- With N simultaneous strobes into an empty FIFO, entries appear on N consecutive cycles in round-robin order from rr_ptr.
- FIFO full: slots hold their contents, and later strobes to held slots are dropped and counted.
- Sustained throughput: 1 nonce/cycle.
- out_nonce/out_core stay stable while out_valid && !out_ready.
- Reset asserted mid-operation clears everything immediately, including in-flight entries.

## Structure
- Package gn_arb_pkg: entry width constant (34 = 2-bit core + 32-bit nonce), DROP_CNT_W=8, NCORES_MAX=4.
- Sub-module gn_fifo: FWFT FIFO parameterised by width/depth, with flush, level, full and empty outputs. Slots, arbiter and counters live in the top.

## Test plan
- Single strobe core 2, nonce 32'h3fbd9207, out_ready=1 → out_valid high 2 cycles later, out_nonce=32'h3fbd9207, out_core=2, one cycle wide.
- All 4 cores strobe in the same cycle, rr_ptr=0 → entries in order 0,1,2,3 on consecutive cycles; rr_ptr ends at 0; drop_cnt=0.
- out_ready=0, 12 strobes from core 0 spaced 1 cycle apart, depth 8 → fifo_level=8, slot holds 1, drop_cnt=3. Then raise out_ready → 9 entries delivered in order.
- new_work while FIFO holds 5 entries and core 1 strobes in the same cycle → out_valid=0 next cycle, fifo_level=0, core 1 nonce never appears, drop_cnt unchanged.
- Core strobes 300 times into a full slot → drop_cnt saturates at 255.
- reset_n pulsed low mid-burst, asynchronously between edges → all outputs 0 immediately. After release, a new strobe is delivered with 2-cycle latency.
